// File: rtl/rope_sequencer.sv
// Per-player rope sequencer for the gold-miner game: swing, extend, collision probe, retract.
// Optional build macro ROPE_SEQ_BOOST_EN lets up_KEY double the retract step.
module rope_sequencer #(
  parameter int unsigned DEG_MIN  = 10,
  parameter int unsigned DEG_MAX  = 170,
  parameter int unsigned DEG_STEP = 2,
  parameter int unsigned EXT_STEP = 4,
  parameter int unsigned MAX_LEN  = 200
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       tick,
  input  logic       down_KEY,
  input  logic       up_KEY,
  output logic       probe_req,
  input  logic       probe_ack,
  input  logic       probe_hit,
  input  logic [1:0] probe_weight,
  output logic [9:0] degree,
  output logic [9:0] rope_len,
  output logic [2:0] state,
  output logic       catch_done,
  output logic       caught,
  output logic [1:0] caught_weight
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] SWING   = 3'd1;
  localparam logic [2:0] EXTEND  = 3'd2;
  localparam logic [2:0] PROBE   = 3'd3;
  localparam logic [2:0] RETRACT = 3'd4;

  localparam logic [9:0]  DEG_HOME  = 10'd90;
  localparam logic [9:0]  DEG_MIN_L = 10'(DEG_MIN);
  localparam logic [9:0]  DEG_MAX_L = 10'(DEG_MAX);
  localparam logic [10:0] DEG_STP_W = 11'(DEG_STEP);
  localparam logic [10:0] EXT_STP_W = 11'(EXT_STEP);
  localparam logic [9:0]  MAX_LEN_L = 10'(MAX_LEN);

  logic [2:0] state_q, state_d;
  logic [9:0] degree_q, degree_d;
  logic [9:0] len_q, len_d;
  logic       dir_up_q, dir_up_d;
  logic       req_q, req_d;
  logic       done_q, done_d;
  logic       caught_q, caught_d;
  logic [1:0] weight_q, weight_d;
  logic       key_prev_q;

  logic        launch;
  logic [4:0]  base_step;
  logic [4:0]  ret_step;
  logic [10:0] deg_inc;
  logic [10:0] deg_dec_floor;
  logic [10:0] ext_sum;

  // Key edge detect runs in every state so a key held through a catch cannot relaunch.
  assign launch = down_KEY & ~key_prev_q;

  always_comb begin
    base_step = 5'd8;
    if (caught_q) begin
      case (weight_q)
        2'd0:    base_step = 5'd8;
        2'd1:    base_step = 5'd4;
        2'd2:    base_step = 5'd2;
        default: base_step = 5'd1;
      endcase
    end
  end

`ifdef ROPE_SEQ_BOOST_EN
  // Base step never exceeds 8, so the boosted step tops out at 16.
  assign ret_step = up_KEY ? {base_step[3:0], 1'b0} : base_step;
`else
  logic unused_up_key;
  assign unused_up_key = up_KEY;
  assign ret_step      = base_step;
`endif

  assign deg_inc       = {1'b0, degree_q} + DEG_STP_W;
  assign deg_dec_floor = {1'b0, DEG_MIN_L} + DEG_STP_W;
  assign ext_sum       = {1'b0, len_q} + EXT_STP_W;

  always_comb begin
    state_d  = state_q;
    degree_d = degree_q;
    len_d    = len_q;
    dir_up_d = dir_up_q;
    req_d    = req_q;
    done_d   = 1'b0;
    caught_d = caught_q;
    weight_d = weight_q;

    // Catch result stays visible only during the catch_done cycle.
    if (done_q) begin
      caught_d = 1'b0;
      weight_d = 2'd0;
    end

    if (!enable) begin
      state_d  = IDLE;
      degree_d = DEG_HOME;
      len_d    = 10'd0;
      dir_up_d = 1'b1;
      req_d    = 1'b0;
      caught_d = 1'b0;
      weight_d = 2'd0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SWING;
          degree_d = DEG_HOME;
          len_d    = 10'd0;
          dir_up_d = 1'b1;
        end

        SWING: begin
          if (launch) begin
            state_d = EXTEND;
          end else if (tick) begin
            if (dir_up_q) begin
              if (deg_inc >= {1'b0, DEG_MAX_L}) begin
                degree_d = DEG_MAX_L;
                dir_up_d = 1'b0;
              end else begin
                degree_d = deg_inc[9:0];
              end
            end else begin
              if ({1'b0, degree_q} <= deg_dec_floor) begin
                degree_d = DEG_MIN_L;
                dir_up_d = 1'b1;
              end else begin
                degree_d = degree_q - DEG_STP_W[9:0];
              end
            end
          end
        end

        EXTEND: begin
          if (tick) begin
            len_d   = (ext_sum >= {1'b0, MAX_LEN_L}) ? MAX_LEN_L : ext_sum[9:0];
            state_d = PROBE;
            req_d   = 1'b1;
          end
        end

        PROBE: begin
          // Ticks arriving here are dropped on purpose.
          if (req_q && probe_ack) begin
            req_d = 1'b0;
            if (probe_hit) begin
              caught_d = 1'b1;
              weight_d = probe_weight;
              state_d  = RETRACT;
            end else if (len_q >= MAX_LEN_L) begin
              state_d = RETRACT;
            end else begin
              state_d = EXTEND;
            end
          end
        end

        RETRACT: begin
          if (tick) begin
            if (len_q <= 10'(ret_step)) begin
              len_d   = 10'd0;
              done_d  = 1'b1;
              state_d = SWING;
            end else begin
              len_d = len_q - 10'(ret_step);
            end
          end
        end

        default: begin
          state_d  = IDLE;
          degree_d = DEG_HOME;
          len_d    = 10'd0;
          dir_up_d = 1'b1;
          req_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      degree_q   <= DEG_HOME;
      len_q      <= 10'd0;
      dir_up_q   <= 1'b1;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      caught_q   <= 1'b0;
      weight_q   <= 2'd0;
      key_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      degree_q   <= degree_d;
      len_q      <= len_d;
      dir_up_q   <= dir_up_d;
      req_q      <= req_d;
      done_q     <= done_d;
      caught_q   <= caught_d;
      weight_q   <= weight_d;
      key_prev_q <= down_KEY;
    end
  end

  assign state         = state_q;
  assign degree        = degree_q;
  assign rope_len      = len_q;
  assign probe_req     = req_q;
  assign catch_done    = done_q;
  assign caught        = caught_q;
  assign caught_weight = weight_q;

endmodule

// File: tb/tb_rope_sequencer.sv
// Self-checking bench for rope_sequencer: directed scenarios plus randomized catches
// checked against a transaction-level model of swing angle and rope length.
module tb_rope_sequencer;

  localparam int DegMin  = 10;
  localparam int DegMax  = 170;
  localparam int DegStep = 2;
  localparam int ExtStep = 4;
  localparam int MaxLen  = 200;

  localparam int SIdle    = 0;
  localparam int SSwing   = 1;
  localparam int SExtend  = 2;
  localparam int SProbe   = 3;
  localparam int SRetract = 4;

  logic       clock = 1'b0;
  logic       resetn;
  logic       enable;
  logic       tick;
  logic       down_KEY;
  logic       up_KEY;
  logic       probe_req;
  logic       probe_ack;
  logic       probe_hit;
  logic [1:0] probe_weight;
  logic [9:0] degree;
  logic [9:0] rope_len;
  logic [2:0] state;
  logic       catch_done;
  logic       caught;
  logic [1:0] caught_weight;

  int checks = 0;
  int errors = 0;
  int m_deg;
  bit m_up;

  always #5 clock = ~clock;

  rope_sequencer dut (
    .clock        (clock),
    .resetn       (resetn),
    .enable       (enable),
    .tick         (tick),
    .down_KEY     (down_KEY),
    .up_KEY       (up_KEY),
    .probe_req    (probe_req),
    .probe_ack    (probe_ack),
    .probe_hit    (probe_hit),
    .probe_weight (probe_weight),
    .degree       (degree),
    .rope_len     (rope_len),
    .state        (state),
    .catch_done   (catch_done),
    .caught       (caught),
    .caught_weight(caught_weight)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic model_home();
    m_deg = 90;
    m_up  = 1'b1;
  endtask

  // Pendulum rule: move by the step, clamp at a bound and turn around there.
  task automatic swing_tick();
    do_tick();
    if (m_up) begin
      m_deg = m_deg + DegStep;
      if (m_deg >= DegMax) begin m_deg = DegMax; m_up = 1'b0; end
    end else begin
      m_deg = m_deg - DegStep;
      if (m_deg <= DegMin) begin m_deg = DegMin; m_up = 1'b1; end
    end
    chk("swing_deg", degree, m_deg);
    chk("swing_state", state, SSwing);
  endtask

  task automatic run_catch(input int hit_len, input int w, input int fixed_delay,
                           input int up_mode, input bit hold_key, input int exp_ticks);
    int len, launch_deg, step_sz, eff, d, rt;
    bit hit, up;
    launch_deg = m_deg;
    hit = 1'b0;
    len = 0;
    rt  = 0;
    down_KEY = 1'b1;
    step();
    if (!hold_key) down_KEY = 1'b0;
    chk("launch_state", state, SExtend);
    chk("launch_deg", degree, launch_deg);
    forever begin
      repeat ($urandom_range(0, 2)) begin
        step();
        chk("ext_wait_state", state, SExtend);
      end
      do_tick();
      len = (len + ExtStep > MaxLen) ? MaxLen : len + ExtStep;
      chk("ext_len", rope_len, len);
      chk("ext_state", state, SProbe);
      chk("ext_req", probe_req, 1);
      d = (fixed_delay >= 0) ? fixed_delay : $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
        if (fixed_delay >= 0) tick = (i == 1 || i == 3);
        else tick = 1'($urandom_range(0, 1));
        step();
        tick = 1'b0;
        chk("probe_req_held", probe_req, 1);
        chk("probe_len_hold", rope_len, len);
        chk("probe_state_hold", state, SProbe);
      end
      probe_ack    = 1'b1;
      probe_hit    = (len == hit_len);
      probe_weight = (len == hit_len) ? 2'(w) : 2'($urandom_range(0, 3));
      step();
      probe_ack = 1'b0;
      probe_hit = 1'b0;
      chk("ack_req_drop", probe_req, 0);
      if (len == hit_len) begin
        hit = 1'b1;
        chk("hit_state", state, SRetract);
        chk("hit_caught", caught, 1);
        chk("hit_weight", caught_weight, w);
        break;
      end else if (len >= MaxLen) begin
        chk("empty_state", state, SRetract);
        chk("empty_caught", caught, 0);
        break;
      end else begin
        chk("miss_state", state, SExtend);
        chk("miss_caught", caught, 0);
      end
    end
    step_sz = hit ? (8 >> w) : 8;
    while (len > 0) begin
      repeat ($urandom_range(0, 1)) begin
        step();
        chk("ret_wait_len", rope_len, len);
        chk("ret_wait_state", state, SRetract);
      end
      up = (up_mode == 2) ? 1'($urandom_range(0, 1)) : (up_mode == 1);
      up_KEY = up;
      do_tick();
      up_KEY = 1'b0;
      rt++;
      eff = step_sz;
`ifdef ROPE_SEQ_BOOST_EN
      if (up) eff = 2 * step_sz;
`endif
      len = (len > eff) ? len - eff : 0;
      chk("ret_len", rope_len, len);
      if (len == 0) begin
        chk("done_pulse", catch_done, 1);
        chk("done_state", state, SSwing);
        chk("done_caught", caught, hit);
        chk("done_weight", caught_weight, hit ? w : 0);
        chk("done_deg", degree, launch_deg);
        if (exp_ticks >= 0) chk("ret_ticks", rt, exp_ticks);
      end else begin
        chk("ret_done_low", catch_done, 0);
        chk("ret_state", state, SRetract);
      end
    end
    step();
    chk("post_done_low", catch_done, 0);
    chk("post_caught_clr", caught, 0);
    chk("post_weight_clr", caught_weight, 0);
    if (hold_key) begin
      repeat (3) begin
        step();
        chk("held_key_no_launch", state, SSwing);
      end
      down_KEY = 1'b0;
      step();
    end
  endtask

  initial begin
    resetn = 1'b0; enable = 1'b0; tick = 1'b0; down_KEY = 1'b0; up_KEY = 1'b0;
    probe_ack = 1'b0; probe_hit = 1'b0; probe_weight = 2'd0;
    model_home();
    #12;
    chk("rst_state", state, SIdle);
    chk("rst_deg", degree, 90);
    chk("rst_len", rope_len, 0);
    chk("rst_req", probe_req, 0);
    chk("rst_done", catch_done, 0);
    chk("rst_caught", caught, 0);
    chk("rst_weight", caught_weight, 0);

    @(posedge clock); #1;
    resetn = 1'b1; enable = 1'b1;
    step();
    chk("enter_swing", state, SSwing);
    chk("enter_deg", degree, 90);

    // Sweep up to the upper bound and back down past home.
    for (int i = 1; i <= 81; i++) begin
      swing_tick();
      if (i == 40) chk("sweep_top", degree, 170);
    end
    chk("sweep_end", degree, 88);

    // A stray ack without a request must be ignored.
    probe_ack = 1'b1; probe_hit = 1'b1; probe_weight = 2'd3;
    step();
    probe_ack = 1'b0; probe_hit = 1'b0; probe_weight = 2'd0;
    chk("stray_ack_req", probe_req, 0);
    chk("stray_ack_caught", caught, 0);
    chk("stray_ack_state", state, SSwing);

    for (int i = 0; i < 200 && m_deg != 100; i++) swing_tick();
    chk("aim_deg", degree, 100);

    run_catch(0, 0, -1, 0, 1'b1, 25);       // empty full-length cast, key held throughout
    chk("empty_deg_kept", degree, 100);
    repeat (3) swing_tick();
    run_catch(40, 3, 5, 0, 1'b0, 40);       // heavy item, slow acks with dropped ticks
`ifdef ROPE_SEQ_BOOST_EN
    repeat (2) swing_tick();
    run_catch(40, 2, -1, 1, 1'b0, 10);
`endif

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(1, 30)) swing_tick();
      run_catch(($urandom_range(0, 3) == 0) ? 0 : 4 * $urandom_range(1, 50),
                $urandom_range(0, 3), -1, 2, 1'b0, -1);
    end

    // enable dropped while probing
    down_KEY = 1'b1; step(); down_KEY = 1'b0;
    do_tick();
    chk("en_probe_state", state, SProbe);
    enable = 1'b0;
    step();
    chk("en_idle_state", state, SIdle);
    chk("en_idle_req", probe_req, 0);
    chk("en_idle_len", rope_len, 0);
    chk("en_idle_deg", degree, 90);
    chk("en_idle_done", catch_done, 0);
    enable = 1'b1;
    step();
    model_home();
    chk("en_resume_state", state, SSwing);

    // asynchronous reset while retracting a weight-3 item
    repeat (5) swing_tick();
    down_KEY = 1'b1; step(); down_KEY = 1'b0;
    do_tick();
    probe_ack = 1'b1; probe_hit = 1'b1; probe_weight = 2'd3;
    step();
    probe_ack = 1'b0; probe_hit = 1'b0; probe_weight = 2'd0;
    do_tick();
    chk("rr_len", rope_len, 3);
    chk("rr_state", state, SRetract);
    resetn = 1'b0;
    #1;
    chk("rr_state_idle", state, SIdle);
    chk("rr_len_zero", rope_len, 0);
    chk("rr_deg_home", degree, 90);
    chk("rr_req", probe_req, 0);
    chk("rr_caught", caught, 0);
    chk("rr_done", catch_done, 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    step();
    model_home();
    chk("rr_resume", state, SSwing);
    swing_tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
